// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// NOP instruction word, PC step, and the timeout-timer width helper.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  // Bits needed to count from 0 up to and including the timeout value.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_buf.sv
// One-entry prefetch buffer holding {pc, instr, valid} for the fetch unit.
// Only built when FETCH_PREFETCH_BUF_EN is defined; the default build has no
// buffer and this file contributes nothing.
`ifdef FETCH_PREFETCH_BUF_EN
module fetch_prefetch_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  input  logic        pop,
  input  logic        flush,
  output logic        buf_valid,
  output logic [31:0] buf_pc,
  output logic [31:0] buf_instr
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  // Flush beats load beats pop; load and pop never coincide in the fetch unit.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // Buffer storage with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign buf_valid = valid_q;
  assign buf_pc    = pc_q;
  assign buf_instr = instr_q;

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, runs req/ack reads to instruction
// memory and presents {if_pc, if_instr} with if_valid to the IF/ID register.
// Branch redirects flush the output and drain any in-flight request; a request
// left unacknowledged for IMEM_TIMEOUT cycles raises a sticky fetch_err.
// Optional feature macro: FETCH_PREFETCH_BUF_EN (one-entry prefetch buffer,
// requests issued while holding, up to one instruction per cycle).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_err
);

  localparam int TMR_W = timer_width(IMEM_TIMEOUT);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;          // address of the next/outstanding request
  logic [31:0]      tgt_q, tgt_d;        // redirect target saved while draining
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W-1:0] timer_inc;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic             fetch_err_q, fetch_err_d;
  logic             req_now;
  logic             deliver;
  logic [31:0]      target;

`ifdef FETCH_PREFETCH_BUF_EN
  logic        buf_load, buf_pop, buf_flush;
  logic        buf_valid;
  logic [31:0] buf_pc, buf_instr;

  fetch_prefetch_buf u_pbuf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_pc    (pc_q),
    .load_instr (imem_rdata),
    .pop        (buf_pop),
    .flush      (buf_flush),
    .buf_valid  (buf_valid),
    .buf_pc     (buf_pc),
    .buf_instr  (buf_instr)
  );
`endif

  // Next-state, request and output-register logic; redirect and timeout
  // override whatever the per-state logic decided.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    timer_d     = timer_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    fetch_err_d = fetch_err_q;
    req_now     = 1'b0;
    deliver     = if_valid_q & ~stall;
    target      = redirect_pc & ~32'h0000_0003;
    timer_inc   = timer_q + TMR_W'(1);
`ifdef FETCH_PREFETCH_BUF_EN
    buf_load    = 1'b0;
    buf_pop     = 1'b0;
    buf_flush   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        req_now = 1'b1;
        if (imem_ack) begin
          if_valid_d = 1'b1;
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          pc_d       = pc_q + PC_INC;
          state_d    = HOLD;
        end
      end
      HOLD: begin
`ifdef FETCH_PREFETCH_BUF_EN
        // Keep fetching ahead whenever the buffer has room.
        req_now = ~buf_valid;
        if (deliver) begin
          if (buf_valid) begin
            if_instr_d = buf_instr;
            if_pc_d    = buf_pc;
            buf_pop    = 1'b1;
          end else if (imem_ack) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            pc_d       = pc_q + PC_INC;
          end else begin
            // Nothing ready to replace the delivered word; keep the
            // outstanding request alive in REQ.
            if_valid_d = 1'b0;
            state_d    = REQ;
          end
        end else if (imem_ack) begin
          buf_load = 1'b1;
          pc_d     = pc_q + PC_INC;
        end
`else
        if (deliver) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end
`endif
      end
      DRAIN: begin
        // Same request stays on the bus; its data is thrown away.
        req_now = 1'b1;
        if (imem_ack) begin
          pc_d    = tgt_q;
          state_d = REQ;
        end
      end
      ERR: begin
        if_valid_d  = 1'b0;
        fetch_err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Wait timer runs only while a request sits unacknowledged.
    timer_d = (req_now && !imem_ack) ? timer_inc : '0;

    if (redirect && state_q != ERR) begin
      if_valid_d = 1'b0;
`ifdef FETCH_PREFETCH_BUF_EN
      buf_flush  = 1'b1;
`endif
      if (req_now && !imem_ack) begin
        pc_d    = pc_q;
        tgt_d   = target;
        state_d = DRAIN;
      end else begin
        pc_d    = target;
        state_d = REQ;
        timer_d = '0;
      end
    end

    if (state_q != ERR && req_now && !imem_ack && timer_inc == TMR_W'(IMEM_TIMEOUT)) begin
      state_d     = ERR;
      if_valid_d  = 1'b0;
      fetch_err_d = 1'b1;
      timer_d     = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, timer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      tgt_q       <= RESET_PC;
      timer_q     <= '0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= NOP_INSTR;
      if_pc_q     <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      timer_q     <= timer_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem_req  = req_now;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory responder with random latency, a
// scoreboard monitor that follows the expected instruction stream (sequential
// PCs, restarted at each redirect target) and directed scenarios for
// throughput, stall, redirect draining, timeout and PC wrap.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam int          TMO    = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_PREFETCH_BUF_EN
  localparam int EXP_GAP = 1;
  localparam int EXP_PF  = 1;
`else
  localparam int EXP_GAP = 2;
  localparam int EXP_PF  = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_dlv   = 0;

  instr_fetch_unit #(.RESET_PC(RST_PC), .IMEM_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  // Reference memory content: every word holds A000_0000 + its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  // ---------------- memory responder ----------------
  int unsigned lat_min = 0;
  int unsigned lat_max = 0;
  int unsigned lat_cnt = 0;
  logic        mem_dead = 1'b0;
  logic        busy_q = 1'b0;
  logic [31:0] junk_q = 32'hDEAD_BEEF;
  logic        fresh;

  assign imem_ack   = imem_req && !mem_dead && (lat_cnt == 0);
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : junk_q;
  assign fresh      = imem_req && !busy_q;

  always @(posedge clk) begin
    junk_q <= $urandom;
    busy_q <= rst && imem_req && !imem_ack;
    if (!rst) lat_cnt <= $urandom_range(lat_max, lat_min);
    else if (imem_req && imem_ack) lat_cnt <= $urandom_range(lat_max, lat_min);
    else if (imem_req && lat_cnt != 0) lat_cnt <= lat_cnt - 1;
  end

  // ---------------- comparison helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [31:0] redir_q[$];   // redirect targets, pushed by stimulus
  logic [31:0] exp_pc = RST_PC;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_pc = RST_PC;
        redir_q.delete();
        prev_wait = 1'b0;
      end else begin
        if (prev_wait && !fetch_err) begin
          check1("req_held", imem_req, 1'b1);
          check("addr_held", imem_addr, prev_addr);
        end
        if (if_valid && !stall) begin
          check("dlv_pc", if_pc, exp_pc);
          check("dlv_instr", if_instr, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          n_dlv++;
        end
        if (redirect) begin
          if (redir_q.size() == 0) check1("redir_queue", 1'b0, 1'b1);
          else exp_pc = redir_q.pop_front() & 32'hFFFF_FFFC;
        end
        prev_wait = imem_req && !imem_ack;
        prev_addr = imem_addr;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    check1({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_addr"}, imem_addr, RST_PC);
    check1({tag, "_valid"}, if_valid, 1'b0);
    check({tag, "_instr"}, if_instr, NOP);
    check({tag, "_pc"}, if_pc, 32'h0);
    check1({tag, "_err"}, fetch_err, 1'b0);
  endtask

  task automatic wait_hs();
    int n = 0;
    while (!(imem_req && imem_ack) && n < 50) begin step(); n++; end
    check1("wait_handshake", imem_req && imem_ack, 1'b1);
  endtask

  task automatic wait_fresh();
    int n = 0;
    while (!fresh && n < 50) begin step(); n++; end
    check1("wait_fresh_req", fresh, 1'b1);
  endtask

  task automatic wait_req(input logic lvl);
    int n = 0;
    while (imem_req !== lvl && n < 50) begin step(); n++; end
    check1("wait_req_level", imem_req, lvl);
  endtask

  task automatic wait_dlv();
    int n = 0;
    while (!(if_valid && !stall) && n < 50) begin step(); n++; end
    check1("wait_delivery", if_valid && !stall, 1'b1);
  endtask

  // Park the fetch unit with a request that memory will never answer.
  task automatic park_dead();
    lat_min = 0;
    lat_max = 0;
    stall   = 1'b1;
    wait_req(1'b0);
    mem_dead = 1'b1;
    stall    = 1'b0;
    step();
    wait_req(1'b1);
  endtask

  task automatic pulse_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    redir_q.push_back(t);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int last, gaps, pf;
    logic [31:0] p0, p1, cap_pc, cap_in, orig;

    // Reset state while rst is held low.
    #12;
    chk_reset_outputs("reset");
    step();
    rst = 1'b1;

    // Zero-wait streaming: throughput and PC wrap at the top of memory.
    last = -1;
    gaps = 0;
    p0 = '0;
    p1 = '1;
    for (int c = 0; c < 40 && gaps < 4; c++) begin
      step();
      if (if_valid && !stall) begin
        if (last < 0) p0 = if_pc;
        else begin
          if (gaps == 0) p1 = if_pc;
          check_int("throughput_gap", c - last, EXP_GAP);
          gaps++;
        end
        last = c;
      end
    end
    check_int("stream_deliveries", gaps, 4);
    check("wrap_first_pc", p0, RST_PC);
    check("wrap_second_pc", p1, 32'h0000_0000);

    // Stall for five cycles while holding an instruction.
    wait_dlv();
    stall  = 1'b1;
    cap_pc = if_pc;
    cap_in = if_instr;
    pf     = 0;
    for (int c = 0; c < 5; c++) begin
      if (imem_req && imem_ack) pf++;
      check("stall_pc_const", if_pc, cap_pc);
      check("stall_instr_const", if_instr, cap_in);
      step();
    end
    check_int("stall_req_count", pf, EXP_PF);
    stall = 1'b0;
    check1("stall_release_valid", if_valid, 1'b1);
    check("stall_release_pc", if_pc, cap_pc);
    step();
    wait_dlv();
    check("after_stall_pc", if_pc, cap_pc + 32'd4);

    // Redirect while a 3-cycle-latency request is outstanding.
    lat_min = 3;
    lat_max = 3;
    wait_hs();
    step();
    wait_fresh();
    orig = imem_addr;
    pulse_redirect(32'h0000_0103);
    step();
    redirect = 1'b0;
    for (int k = 1; k < 3; k++) begin
      check1("drain_req", imem_req, 1'b1);
      check("drain_addr", imem_addr, orig);
      check1("drain_noack", imem_ack, 1'b0);
      check1("drain_valid", if_valid, 1'b0);
      step();
    end
    check1("drain_ack", imem_ack, 1'b1);
    check("drain_ack_addr", imem_addr, orig);
    step();
    check1("drain_next_req", imem_req, 1'b1);
    check("drain_next_addr", imem_addr, 32'h0000_0100);
    check1("drain_next_valid", if_valid, 1'b0);

    // Redirect in the same cycle as an ack, with stall asserted.
    lat_min = 0;
    lat_max = 0;
    wait_hs();
    step();
    wait_hs();
    pulse_redirect(32'h0000_0206);
    stall = 1'b1;
    step();
    redirect = 1'b0;
    check1("redir_ack_valid", if_valid, 1'b0);
    check1("redir_ack_req", imem_req, 1'b1);
    check("redir_ack_addr", imem_addr, 32'h0000_0204);
    stall = 1'b0;
    for (int c = 0; c < 6; c++) step();

    // Memory never answers: timeout after TMO waiting cycles.
    park_dead();
    for (int k = 1; k < TMO; k++) begin
      step();
      check1("tmo_err_early", fetch_err, 1'b0);
      check1("tmo_req_early", imem_req, 1'b1);
    end
    step();
    check1("tmo_err", fetch_err, 1'b1);
    check1("tmo_req_drop", imem_req, 1'b0);
    check1("tmo_valid", if_valid, 1'b0);
    step();
    step();
    check1("tmo_err_sticky", fetch_err, 1'b1);

    // Reset out of the error state.
    rst = 1'b0;
    #1;
    chk_reset_outputs("err_rst");
    step();
    step();
    mem_dead = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) step();

    // Asynchronous reset in the middle of a waiting request.
    park_dead();
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    mem_dead = 1'b0;
    step();
    step();
    rst = 1'b1;

    // Random stall, latency and redirects against the stream model.
    lat_min = 0;
    lat_max = 3;
    pf = n_dlv;
    for (int c = 0; c < 400; c++) begin
      step();
      redirect = 1'b0;
      stall = ($urandom_range(99, 0) < 30);
      if ($urandom_range(99, 0) < 4) pulse_redirect($urandom);
    end
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    for (int c = 0; c < 20; c++) step();
    check1("random_progress", n_dlv > pf + 50, 1'b1);
    check1("random_no_err", fetch_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
